// File: rtl/log_readout_sequencer.sv
// log_readout_sequencer: host-side sequencer that arms memlog, polls for full, then streams every log entry out.
// Define LOG_SEQ_BER_SNAP_EN to append a BER_Q snapshot readout (four flagged words) after the last entry.
module log_readout_sequencer #(
  parameter int NB_GPIOS  = 32,
  parameter int N_DATA    = 22,
  parameter int NB_ADDR   = 10,
  parameter int LOG_DEPTH = 1024,
  parameter int RESP_WAIT = 2,
  parameter int POLL_GAP  = 16,
  parameter int POLL_MAX  = 65535
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_abort,
  output logic [NB_GPIOS-1:0] o_gpio_cmd,
  input  logic [NB_GPIOS-1:0] i_gpio_rsp,
  output logic [N_DATA-1:0]   o_data,
  output logic [NB_ADDR-1:0]  o_addr,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_done,
`ifdef LOG_SEQ_BER_SNAP_EN
  output logic                o_ber_flag,
`endif
  output logic                o_timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_POLL, S_POLL_WAIT, S_RDMODE, S_SETADDR, S_FETCH, S_PRESENT,
    S_BER_SNAP, S_BER_RD, S_BER_PRES, S_DONE
  } state_e;

  localparam int                 DW        = NB_GPIOS - 9;
  localparam logic [15:0]        RESP_LAST = 16'(RESP_WAIT + 1);
  localparam logic [15:0]        GAP_LAST  = 16'(POLL_GAP - 1);
  localparam logic [15:0]        POLL_LAST = 16'(POLL_MAX - 1);
  localparam logic [NB_ADDR-1:0] ADDR_LAST = NB_ADDR'(LOG_DEPTH - 1);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d, poll_cnt_q, poll_cnt_d;
  logic [NB_ADDR-1:0]  addr_q, addr_d, oaddr_q, oaddr_d;
  logic [N_DATA-1:0]   data_q, data_d;
  logic                valid_q, valid_d, busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic [NB_GPIOS-1:0] gpio_q, gpio_d;
  logic [7:0]          cmd_s;
  logic [DW-1:0]       arg_s;
  logic                last_s;
  logic                unused_rsp_s;
`ifdef LOG_SEQ_BER_SNAP_EN
  logic [1:0]          ber_k_q, ber_k_d;
  logic                ber_flag_q, ber_flag_d;
`endif

  assign unused_rsp_s = ^i_gpio_rsp;

  // Next-state logic; cnt_q is the command phase (0=H, 1=L, then waits) or the poll gap timer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    poll_cnt_d = poll_cnt_q;
    addr_d     = addr_q;
    oaddr_d    = oaddr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    timeout_d  = timeout_q;
`ifdef LOG_SEQ_BER_SNAP_EN
    ber_k_d    = ber_k_q;
    ber_flag_d = ber_flag_q;
`endif
    last_s = (cnt_q == RESP_LAST);
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_ARM;
          cnt_d     = 16'd0;
          timeout_d = 1'b0;
        end else begin
          cnt_d = 16'd0;
        end
      end
      S_ARM: begin
        if (last_s) begin
          state_d    = S_POLL;
          cnt_d      = 16'd0;
          poll_cnt_d = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_POLL: begin
        if (last_s) begin
          cnt_d = 16'd0;
          if (i_gpio_rsp[0]) begin
            state_d = S_RDMODE;
          end else if (poll_cnt_q == POLL_LAST) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end else begin
            state_d    = S_POLL_WAIT;
            poll_cnt_d = poll_cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_POLL_WAIT: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_POLL;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RDMODE: begin
        if (last_s) begin
          state_d = S_SETADDR;
          cnt_d   = 16'd0;
          addr_d  = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SETADDR: begin
        if (last_s) begin
          state_d = S_FETCH;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_FETCH: begin
        if (last_s) begin
          state_d = S_PRESENT;
          cnt_d   = 16'd0;
          data_d  = i_gpio_rsp[N_DATA-1:0];
          oaddr_d = addr_q;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_PRESENT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          cnt_d   = 16'd0;
          if (addr_q == ADDR_LAST) begin
`ifdef LOG_SEQ_BER_SNAP_EN
            state_d = S_BER_SNAP;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_SETADDR;
            addr_d  = addr_q + 1'b1;
          end
        end else begin
          cnt_d = 16'd0;
        end
      end
`ifdef LOG_SEQ_BER_SNAP_EN
      S_BER_SNAP: begin
        if (last_s) begin
          state_d = S_BER_RD;
          cnt_d   = 16'd0;
          ber_k_d = 2'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BER_RD: begin
        if (last_s) begin
          state_d    = S_BER_PRES;
          cnt_d      = 16'd0;
          data_d     = i_gpio_rsp[N_DATA-1:0];
          oaddr_d    = NB_ADDR'(LOG_DEPTH + int'(ber_k_q));
          valid_d    = 1'b1;
          ber_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BER_PRES: begin
        if (i_ready) begin
          valid_d    = 1'b0;
          ber_flag_d = 1'b0;
          cnt_d      = 16'd0;
          if (ber_k_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BER_RD;
            ber_k_d = ber_k_q + 2'd1;
          end
        end else begin
          cnt_d = 16'd0;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort returns to an all-zero bus; a start in the same cycle is dropped and o_timeout is kept.
    if (i_abort) begin
      state_d   = S_IDLE;
      cnt_d     = 16'd0;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
`ifdef LOG_SEQ_BER_SNAP_EN
      ber_flag_d = 1'b0;
`endif
    end else begin
      valid_d = valid_d;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    arg_s = '0;
    case (state_d)
      S_ARM:      cmd_s = 8'h04;
      S_POLL:     cmd_s = 8'h09;
      S_RDMODE:   cmd_s = 8'h05;
      S_SETADDR: begin
        cmd_s               = 8'h07;
        arg_s[NB_ADDR-1:0]  = addr_d;
      end
      S_FETCH:    cmd_s = 8'h10;
`ifdef LOG_SEQ_BER_SNAP_EN
      S_BER_SNAP: cmd_s = 8'h03;
      S_BER_RD: begin
        cmd_s          = 8'h11;
        arg_s[ber_k_d] = 1'b1;
      end
`endif
      default:    cmd_s = 8'h00;
    endcase

    // Enable is high only in phase 0; cmd/data are the same in phases 0 and 1.
    if ((cmd_s != 8'h00) && (cnt_d <= 16'd1)) begin
      gpio_d = {cmd_s, (cnt_d == 16'd0), arg_s};
    end else begin
      gpio_d = '0;
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      poll_cnt_q <= 16'd0;
      addr_q     <= '0;
      oaddr_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      gpio_q     <= '0;
`ifdef LOG_SEQ_BER_SNAP_EN
      ber_k_q    <= 2'd0;
      ber_flag_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poll_cnt_q <= poll_cnt_d;
      addr_q     <= addr_d;
      oaddr_q    <= oaddr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      gpio_q     <= gpio_d;
`ifdef LOG_SEQ_BER_SNAP_EN
      ber_k_q    <= ber_k_d;
      ber_flag_q <= ber_flag_d;
`endif
    end
  end

  assign o_gpio_cmd = gpio_q;
  assign o_data     = data_q;
  assign o_addr     = oaddr_q;
  assign o_valid    = valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_timeout  = timeout_q;
`ifdef LOG_SEQ_BER_SNAP_EN
  assign o_ber_flag = ber_flag_q;
`endif

endmodule

// File: tb/tb_log_readout_sequencer.sv
// Bench for log_readout_sequencer: register-file model on the GPIO bus, vector table of capture runs,
// scoreboard of expected stream words, plus hand-written reset/abort/backpressure sequences.
module tb_log_readout_sequencer;
  localparam int DEPTH = 4;
  localparam int PMAX  = 5;
  localparam int RW    = 2;
  localparam int ENTRY_CYC = 2 * (2 + RW) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] gpio_cmd;
  logic [31:0] gpio_rsp;
  logic [21:0] data;
  logic [9:0]  addr;
  logic        valid, busy, done, tmo;
`ifdef LOG_SEQ_BER_SNAP_EN
  logic        ber_flag;
`endif

  always #5 clk = ~clk;

  log_readout_sequencer #(
    .NB_GPIOS(32), .N_DATA(22), .NB_ADDR(10), .LOG_DEPTH(DEPTH),
    .RESP_WAIT(RW), .POLL_GAP(16), .POLL_MAX(PMAX)
  ) dut (
    .clock(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort),
    .o_gpio_cmd(gpio_cmd), .i_gpio_rsp(gpio_rsp),
    .o_data(data), .o_addr(addr), .o_valid(valid), .i_ready(ready),
    .o_busy(busy), .o_done(done),
`ifdef LOG_SEQ_BER_SNAP_EN
    .o_ber_flag(ber_flag),
`endif
    .o_timeout(tmo)
  );

  // Register-file model: executes a command on the enable falling edge.
  logic [21:0] mem [DEPTH];
  int          full_at = 0;
  int          m_polls = 0, m_run_polls = 0, m_arms = 0, m_nops = 0, m_bad_edges = 0;
  logic [9:0]  m_addr = 10'd0;
  logic [31:0] m_prev = 32'd0;
  logic [31:0] m_rsp  = 32'd0;
  logic [31:0] ber_words [4] = '{32'h0000_0064, 32'h0000_0000, 32'h0000_0003, 32'h0000_0000};

  assign gpio_rsp = m_rsp;

  always @(negedge clk) begin
    if (m_prev[23] && !gpio_cmd[23]) begin
      if (gpio_cmd != 32'd0 && gpio_cmd[31:24] != m_prev[31:24] || gpio_cmd != 32'd0 && gpio_cmd[22:0] != m_prev[22:0])
        m_bad_edges <= m_bad_edges + 1;
      case (gpio_cmd[31:24])
        8'h04: begin m_arms <= m_arms + 1; m_run_polls <= 0; m_rsp <= 32'd0; end
        8'h09: begin
          m_polls     <= m_polls + 1;
          m_run_polls <= m_run_polls + 1;
          m_rsp       <= (full_at != 0 && m_run_polls + 1 >= full_at) ? 32'd1 : 32'd0;
        end
        8'h07: m_addr <= gpio_cmd[9:0];
        8'h10: m_rsp <= {10'd0, mem[m_addr[1:0]]};
        8'h11: begin
          case (gpio_cmd[3:0])
            4'h1:    m_rsp <= ber_words[0];
            4'h2:    m_rsp <= ber_words[1];
            4'h4:    m_rsp <= ber_words[2];
            4'h8:    m_rsp <= ber_words[3];
            default: m_rsp <= 32'hDEAD_BEEF;
          endcase
        end
        8'h00: m_nops <= m_nops + 1;
        default: m_rsp <= m_rsp;
      endcase
    end
    m_prev <= gpio_cmd;
  end

  typedef struct packed { logic [9:0] a; logic [21:0] d; } exp_t;
  exp_t sb[$];

  typedef struct {
    int              full_at;
    logic [3:0][21:0] e;
    int              bp_addr;
    int              exp_polls;
    logic            exp_tmo;
    logic            exp_done;
  } vec_t;
  vec_t vecs[4];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc, last_acc, held, polls0;
    logic finished;
    exp_t x;
    polls0 = m_polls;
    for (int i = 0; i < DEPTH; i++) mem[i] = v.e[i];
    full_at = v.full_at;
    if (!v.exp_tmo) begin
      for (int i = 0; i < DEPTH; i++) sb.push_back({10'(i), v.e[i]});
`ifdef LOG_SEQ_BER_SNAP_EN
      for (int k = 0; k < 4; k++) sb.push_back({10'(DEPTH + k), ber_words[k][21:0]});
`endif
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("arm_h_word", gpio_cmd, 32'h0480_0000);
    check("busy_after_start", busy, 1'b1);
    check("timeout_cleared_by_start", tmo, 1'b0);
    @(negedge clk);
    check("arm_l_word", gpio_cmd, 32'h0400_0000);
    cyc = 0; last_acc = -1; held = 0; finished = 1'b0;
    while (!finished && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (v.bp_addr >= 0 && valid && addr == 10'(v.bp_addr) && held < 10) begin
        ready = 1'b0;
        held++;
        check("bp_data_stable", data, v.e[v.bp_addr]);
        check("bp_addr_stable", addr, v.bp_addr);
        check("bp_no_command", gpio_cmd, 32'd0);
      end else begin
        ready = 1'b1;
      end
      if (valid && ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word_addr", addr, 32'hFFFF_FFFF);
        end else begin
          x = sb.pop_front();
          check("stream_addr", addr, x.a);
          check("stream_data", data, x.d);
`ifdef LOG_SEQ_BER_SNAP_EN
          check("ber_flag", ber_flag, (x.a >= 10'(DEPTH)));
`endif
          if (v.bp_addr < 0 && last_acc >= 0 && addr != 10'd0 && addr < 10'(DEPTH))
            check("entry_period", cyc - last_acc, ENTRY_CYC);
          last_acc = cyc;
        end
      end
      if (done || tmo) finished = 1'b1;
    end
    ready = 1'b1;
    check("run_finished_in_budget", finished, 1'b1);
    check("done_at_end", done, v.exp_done);
    check("timeout_at_end", tmo, v.exp_tmo);
    check("poll_count", m_polls - polls0, v.exp_polls);
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
    check("busy_off_after_run", busy, 1'b0);
    check("idle_word_zero", gpio_cmd, 32'd0);
  endtask

  initial begin
    int   arms0, nops0, cyc;
    logic found;

    vecs[0] = '{3, {22'h2AAAAA, 22'h155555, 22'h000001, 22'h3FFFFF}, -1, 3, 1'b0, 1'b1};
    vecs[1] = '{1, {22'h2AAAAA, 22'h155555, 22'h000001, 22'h3FFFFF},  1, 1, 1'b0, 1'b1};
    vecs[2] = '{0, {22'h000000, 22'h000000, 22'h000000, 22'h000000}, -1, 5, 1'b1, 1'b0};
    vecs[3] = '{5, {22'h0F0F0F, 22'h000000, 22'h3C3C3C, 22'h123456}, -1, 5, 1'b0, 1'b1};

    // Reset, then idle for 20 cycles
    repeat (3) @(negedge clk);
    check("reset_valid", valid, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_timeout", tmo, 1'b0);
    check("reset_data", data, 32'd0);
    check("reset_addr", addr, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_word", gpio_cmd, 32'd0);
      check("idle_busy", busy, 1'b0);
    end

    // Start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 1'b0);
    check("start_abort_word", gpio_cmd, 32'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Abort in the H cycle of the 0x07 for address 2; a stray start while busy is ignored
    for (int i = 0; i < DEPTH; i++) mem[i] = vecs[0].e[i];
    full_at = 1;
    arms0 = m_arms;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0; cyc = 0;
    while (!found && cyc < 3000) begin
      @(negedge clk); cyc++;
      start = (cyc == 10);
      if (gpio_cmd[31:24] == 8'h07 && gpio_cmd[23] && gpio_cmd[9:0] == 10'd2) found = 1'b1;
    end
    start = 1'b0;
    check("abort_target_reached", found, 1'b1);
    check("start_while_busy_ignored", m_arms - arms0, 1);
    nops0 = m_nops;
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_word_zero", gpio_cmd, 32'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_valid", valid, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_nop_fall", m_nops - nops0, 1);
    check("abort_addr_not_set", m_addr, 10'd1);
    check("abort_no_done", done, 1'b0);
    run_vec(vecs[0]);

    // Reset clears a sticky timeout; reset mid-run returns to idle
    run_vec(vecs[2]);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("reset_clears_timeout", tmo, 1'b0);
    full_at = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_reset_word", gpio_cmd, 32'd0);
    check("midrun_reset_busy", busy, 1'b0);
    check("midrun_reset_valid", valid, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle_busy", busy, 1'b0);
    check("enable_fall_cmd_stable", m_bad_edges, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/log_readout_sequencer.md
Name: log_readout_sequencer

Overview:
- Host-side controller that drives the register-file GPIO command bus to run one complete log capture.
- Sequence: arm memlog, poll mem-full, switch to read mode, walk every log address, stream each 22-bit entry out on a valid/ready port.
- Sits between the host-side processor/UART bridge and the register file's GPIO input/output pair.
- Replaces software bit-banging of the enable-falling-edge command protocol.

Parameters:
- NB_GPIOS, 32, GPIO word width.
- N_DATA, 22, log entry width.
- NB_ADDR, 10, log address width.
- LOG_DEPTH, 1024, number of entries read, 1..2^NB_ADDR.
- RESP_WAIT, 2, idle cycles after a command's enable-low cycle before o_gpio is sampled (min 1).
- POLL_GAP, 16, cycles between consecutive 0x09 polls.
- POLL_MAX, 65535, polls allowed before timeout; 16-bit counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle start request; honoured only in IDLE.
- i_abort  in  1  synchronous abort.
- o_gpio_cmd  out  NB_GPIOS  command word to register-file i_gpio: [31:24] cmd, [23] enable, [22:0] data.
- i_gpio_rsp  in  NB_GPIOS  register-file o_gpio.
- o_data  out  N_DATA  log entry.
- o_addr  out  NB_ADDR  address of o_data.
- o_valid  out  1  o_data/o_addr valid.
- i_ready  in  1  consumer accepts when o_valid & i_ready.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse on successful completion.
- o_timeout  out  1  sticky; set on poll timeout, cleared by next accepted i_start or reset.

Behaviour:
- Reset values: o_gpio_cmd=0, o_valid=0, o_data=0, o_addr=0, o_busy=0, o_done=0, o_timeout=0; state IDLE.
- Command issue primitive, 2 cycles:
  - Cycle H: o_gpio_cmd={cmd,1'b1,data}.
  - Cycle L: o_gpio_cmd={cmd,1'b0,data}, cmd/data unchanged.
  - Then word goes to 0 and RESP_WAIT wait cycles follow.
  - Response is sampled on the last wait cycle.
- Enable never falls with a cmd/data different from the one presented while it was high.
- cmd 0x00 is a register-file no-op, so all-zero is the safe idle word.
- States:
  - IDLE: i_start -> ARM; clears o_timeout.
  - ARM: issue 0x04 -> POLL.
  - POLL: issue 0x09; if sampled i_gpio_rsp[0]=1 -> RDMODE.
    - Else wait POLL_GAP cycles and repoll.
    - Poll count reaching POLL_MAX without full -> set o_timeout -> IDLE; no o_done.
  - RDMODE: issue 0x05, addr counter=0 -> SETADDR.
  - SETADDR: issue 0x07 with data[NB_ADDR-1:0]=addr, upper data bits 0 -> FETCH.
  - FETCH: issue 0x10; capture i_gpio_rsp[N_DATA-1:0] into o_data and addr into o_addr; set o_valid -> PRESENT.
  - PRESENT: hold o_data/o_addr/o_valid stable until i_ready.
    - On the accept cycle o_valid drops next cycle.
    - If addr==LOG_DEPTH-1 -> DONE, else addr+1 -> SETADDR.
  - DONE: o_done=1 for one cycle -> IDLE.
- Throughput: with i_ready held high, one entry per 2*(2+RESP_WAIT)+1 cycles.
- i_start while busy: ignored.
- i_start and i_abort in the same IDLE cycle: abort wins, stay IDLE.
- i_abort in any state (takes effect next cycle):
  - State goes to IDLE; o_gpio_cmd=0, o_valid=0; no o_done.
  - If abort lands in cycle H, the following all-zero word produces a falling edge with cmd 0x00, which is harmless.
- i_reset mid-operation: same outputs as abort, plus o_timeout cleared.
- Address counter never wraps; terminal compare is exact at LOG_DEPTH-1.

Optional Feature:
- Macro: LOG_SEQ_BER_SNAP_EN.
- Defined:
  - Between last-entry accept and DONE, issue 0x03 (snapshot BER_Q).
  - Then issue 0x11 four times with data=1,2,4,8.
  - Each response is streamed as a full-width word: low N_DATA bits on o_data, upper bits dropped, o_addr=LOG_DEPTH+k (k=0..3 truncated to NB_ADDR).
  - Adds output o_ber_flag (1), high with o_valid for these four words; reset 0.
- Undefined: port absent; PRESENT goes straight to DONE after the last entry.

Test Plan:
- Reset then idle: after i_reset low 3 cycles, o_gpio_cmd==0, o_busy==0 for 20 cycles.
- Nominal run:
  - Setup: LOG_DEPTH=4, model asserts full on 3rd poll, entries 0x3FFFFF,0x000001,0x155555,0x2AAAAA, i_ready=1.
  - Required response: first command word 0x04800000 then 0x04000000; 3 polls; stream addr 0..3 with those values; o_done one pulse.
- Backpressure: i_ready low 10 cycles on addr 1 -> o_data=0x000001 and o_addr=1 stable; no new command issued until accept.
- Timeout: POLL_MAX=5, full never asserted -> exactly five 0x09 commands, o_timeout=1, o_done=0, IDLE.
  - Next i_start clears o_timeout.
- Abort in H cycle of 0x07: next cycle word==0; model sees only cmd 0x00 falling edge; o_busy=0.
  - Subsequent i_start restarts from addr 0.
- With LOG_SEQ_BER_SNAP_EN: BER_Q error count 0x0000_0003_0000_0064 -> after log entries, 4 flagged words with low bits 0x000064 (lo count), 0x000000, 0x000003, 0x000000, per model values.
